// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID pipeline register outputs of the fetch stage.
// The master side is the fetch stage; the slave side is the instruction memory and decode.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Handles branch/JR/jump redirects, decode stalls and a HALT opcode that stops fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                clock,
    input  logic                reset,
    fetch_stage_if.master       bus,
    input  logic                stall,
    input  logic                jump,
    input  logic [25:0]         jump_index,
    input  logic                jump_reg,
    input  logic [31:0]         jr_addr,
    input  logic                branch_taken,
    input  logic [31:0]         branch_pc4,
    input  logic [15:0]         branch_offset,
    input  logic                halt_retired,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = branch_taken | jump_reg | jump;

    // Oldest instruction wins: EX branch, then JR, then the ID-stage jump.
    always_comb begin
        if (branch_taken)
            redirect_target = branch_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        else if (jump_reg)
            redirect_target = jr_addr;
        else
            redirect_target = {pc4_q[31:28], jump_index, 2'b00};
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = bus.imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_q + 32'd1;
                    if (bus.imem_rdata[31:26] == HALT_OPCODE)
                        state_d = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                // A redirect here means the HALT was on a mispredicted path.
                if (redirect) begin
                    pc_d    = redirect_target;
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (halt_retired) begin
                    instr_d  = 32'h0;
                    pc4_d    = 32'h0;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end else if (!stall) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            pc4_q    <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign halted          = halted_q;
    assign fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a vector table for fetch/stall/redirect
// plus hand-written HALT sequences and asynchronous reset checks.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall, jump, jump_reg, branch_taken, halt_retired;
    logic [25:0] jump_index;
    logic [31:0] jr_addr, branch_pc4;
    logic [15:0] branch_offset;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] halt_addr = 32'hFFFF_FFFF;

    int total = 0;
    int bad   = 0;

    fetch_stage_if bus ();

    // Instruction memory: HALT at halt_addr, else 0x04000000 | word index.
    assign bus.imem_rdata = (bus.imem_addr == halt_addr) ? 32'hFC00_0000
                                                         : (32'h0400_0000 | (bus.imem_addr >> 2));

    fetch_stage dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .stall        (stall),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_addr      (jr_addr),
        .branch_taken (branch_taken),
        .branch_pc4   (branch_pc4),
        .branch_offset(branch_offset),
        .halt_retired (halt_retired),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [25:0] jidx;
        logic        jreg;
        logic [31:0] jra;
        logic        br;
        logic [31:0] bpc4;
        logic [15:0] boff;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; jump = 0; jump_index = '0; jump_reg = 0; jr_addr = '0;
        branch_taken = 0; branch_pc4 = '0; branch_offset = '0; halt_retired = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.imem_addr, 32'h0);
        chk("async_rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
        chk("async_rst_instr", bus.if_id_instr, 32'h0);
        chk("async_rst_halted", {31'b0, halted}, 32'h0);
        chk("async_rst_count", fetch_count, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        //            stall jmp jidx     jr jra            br bpc4        boff      e_pc          e_instr       e_pc4         v  cnt
        vec[0]  = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h4,         32'h0400_0000, 32'h4,         1, 1};
        vec[1]  = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h8,         32'h0400_0001, 32'h8,         1, 2};
        vec[2]  = '{1, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h8,         32'h0400_0001, 32'h8,         1, 2};
        vec[3]  = '{1, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h8,         32'h0400_0001, 32'h8,         1, 2};
        vec[4]  = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'hC,         32'h0400_0002, 32'hC,         1, 3};
        vec[5]  = '{0, 1, 26'h40, 0, 32'h0,          1, 32'h20,    16'hFFFC, 32'h10,        32'h0,         32'h0,         0, 3};
        vec[6]  = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h14,        32'h0400_0004, 32'h14,        1, 4};
        vec[7]  = '{0, 0, 26'h0,  1, 32'h1000_0000,  0, 32'h0,     16'h0,    32'h1000_0000, 32'h0,         32'h0,         0, 4};
        vec[8]  = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h1000_0004, 32'h0400_0000, 32'h1000_0004, 1, 5};
        vec[9]  = '{1, 1, 26'h40, 0, 32'h0,          0, 32'h0,     16'h0,    32'h1000_0100, 32'h0,         32'h0,         0, 5};
        vec[10] = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h1000_0104, 32'h0400_0040, 32'h1000_0104, 1, 6};
        vec[11] = '{0, 1, 26'h40, 1, 32'h200,        0, 32'h0,     16'h0,    32'h200,       32'h0,         32'h0,         0, 6};
        vec[12] = '{0, 0, 26'h0,  1, 32'h300,        1, 32'h100,   16'h0004, 32'h110,       32'h0,         32'h0,         0, 6};
        vec[13] = '{0, 0, 26'h0,  0, 32'h0,          0, 32'h0,     16'h0,    32'h114,       32'h0400_0044, 32'h114,       1, 7};

        // Power-on reset state.
        #3;
        chk("rst_pc", bus.imem_addr, 32'h0);
        chk("rst_instr", bus.if_id_instr, 32'h0);
        chk("rst_pc4", bus.if_id_pc4, 32'h0);
        chk("rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            stall = vec[i].stall; jump = vec[i].jump; jump_index = vec[i].jidx;
            jump_reg = vec[i].jreg; jr_addr = vec[i].jra; branch_taken = vec[i].br;
            branch_pc4 = vec[i].bpc4; branch_offset = vec[i].boff;
            tick();
            $display("vec %0d: pc=%h instr=%h pc4=%h valid=%0d count=%0d",
                     i, bus.imem_addr, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, fetch_count);
            chk($sformatf("vec%0d_pc", i), bus.imem_addr, vec[i].e_pc);
            chk($sformatf("vec%0d_instr", i), bus.if_id_instr, vec[i].e_instr);
            chk($sformatf("vec%0d_valid", i), {31'b0, bus.if_id_valid}, {31'b0, vec[i].e_valid});
            chk($sformatf("vec%0d_count", i), fetch_count, vec[i].e_cnt);
            if (vec[i].e_valid)
                chk($sformatf("vec%0d_pc4", i), bus.if_id_pc4, vec[i].e_pc4);
        end

        // HALT at 0x30, retire it, then redirects are ignored.
        halt_addr = 32'h30;
        do_reset();
        jump_reg = 1; jr_addr = 32'h30;
        tick();
        idle_inputs();
        chk("hA_jr_pc", bus.imem_addr, 32'h30);
        tick();
        $display("halt A: HALT loaded pc=%h instr=%h count=%0d", bus.imem_addr, bus.if_id_instr, fetch_count);
        chk("hA_instr", bus.if_id_instr, 32'hFC00_0000);
        chk("hA_valid", {31'b0, bus.if_id_valid}, 32'h1);
        chk("hA_pc", bus.imem_addr, 32'h34);
        chk("hA_count", fetch_count, 32'h1);
        tick();
        tick();
        chk("hA_wait_pc", bus.imem_addr, 32'h34);
        chk("hA_wait_bubble", {31'b0, bus.if_id_valid}, 32'h0);
        chk("hA_wait_count", fetch_count, 32'h1);
        chk("hA_wait_halted", {31'b0, halted}, 32'h0);
        halt_retired = 1;
        tick();
        halt_retired = 0;
        $display("halt A: retired halted=%0d pc=%h", halted, bus.imem_addr);
        chk("hA_halted", {31'b0, halted}, 32'h1);
        branch_taken = 1; branch_pc4 = 32'h100; branch_offset = 16'h0010;
        jump_reg = 1; jr_addr = 32'h500; jump = 1; jump_index = 26'h3;
        tick();
        tick();
        idle_inputs();
        tick();
        chk("hA_frozen_pc", bus.imem_addr, 32'h34);
        chk("hA_frozen_halted", {31'b0, halted}, 32'h1);
        chk("hA_frozen_valid", {31'b0, bus.if_id_valid}, 32'h0);
        chk("hA_frozen_count", fetch_count, 32'h1);

        // Reset out of HALTED, then HALT squashed by a branch in HALT_WAIT.
        do_reset();
        jump_reg = 1; jr_addr = 32'h30;
        tick();
        idle_inputs();
        tick();
        chk("hB_halt_pc", bus.imem_addr, 32'h34);
        branch_taken = 1; branch_pc4 = 32'h34; branch_offset = 16'h0002;
        halt_retired = 1;
        tick();
        idle_inputs();
        $display("halt B: branch in HALT_WAIT pc=%h halted=%0d", bus.imem_addr, halted);
        chk("hB_redir_pc", bus.imem_addr, 32'h3C);
        chk("hB_redir_valid", {31'b0, bus.if_id_valid}, 32'h0);
        chk("hB_redir_halted", {31'b0, halted}, 32'h0);
        tick();
        chk("hB_run_instr", bus.if_id_instr, 32'h0400_000F);
        chk("hB_run_pc4", bus.if_id_pc4, 32'h40);
        chk("hB_run_count", fetch_count, 32'h2);
        chk("hB_run_pc", bus.imem_addr, 32'h40);

        // HALT fetched under a redirect is flushed; fetch keeps running.
        halt_addr = 32'h40;
        jump_reg = 1; jr_addr = 32'h80;
        tick();
        idle_inputs();
        chk("hC_flush_pc", bus.imem_addr, 32'h80);
        chk("hC_flush_valid", {31'b0, bus.if_id_valid}, 32'h0);
        tick();
        $display("halt C: after flushed HALT pc=%h instr=%h", bus.imem_addr, bus.if_id_instr);
        chk("hC_run_instr", bus.if_id_instr, 32'h0400_0020);
        chk("hC_run_pc", bus.imem_addr, 32'h84);
        chk("hC_run_count", fetch_count, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
